// File: rtl/sos_multi_dist_calc_pkg.sv
`default_nettype none
// ==========================================================================
// sos_multi_dist_calc_pkg : FSM state type and width helpers.  Rev 1.0
// ==========================================================================
package sos_multi_dist_calc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRE   = 2'd1,
      LISTEN = 2'd2,
      DONE   = 2'd3
   } fsm_t;

   // Window sum width: a full window of the largest magnitude can never wrap.
   function automatic int sum_width(input int sample_w, input int window_size);
      return sample_w + $clog2(window_size);
   endfunction

   function automatic int delay_width(input int max_delay);
      return $clog2(max_delay + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sos_multi_dist_calc_if.sv
`default_nettype none
// ==========================================================================
// sos_multi_dist_calc_if : strobe, mic, impulse handshake and result bus.  Rev 1.0
// ==========================================================================
interface sos_multi_dist_calc_if #(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 16,
   parameter int DELAY_W  = 10
);
   logic                         step_in;
   logic                         trigger_in;
   logic [NUM_CH*SAMPLE_W-1:0]   mic_in;
   logic                         impulse_req_out;
   logic                         impulse_done_in;
   logic                         busy_out;
   logic [NUM_CH*DELAY_W-1:0]    delay_out;
   logic [NUM_CH-1:0]            delay_valid_out;
   logic [NUM_CH-1:0]            fail_out;
   logic                         done_out;

   modport master (
      output step_in, trigger_in, mic_in, impulse_done_in,
      input  impulse_req_out, busy_out, delay_out, delay_valid_out, fail_out, done_out
   );

   modport slave (
      input  step_in, trigger_in, mic_in, impulse_done_in,
      output impulse_req_out, busy_out, delay_out, delay_valid_out, fail_out, done_out
   );
endinterface
`default_nettype wire

// File: rtl/sos_multi_dist_calc_onset_window_detector.sv
`default_nettype none
// ==========================================================================
// sos_multi_dist_calc_onset_window_detector : per-channel energy-window onset detector.  Rev 1.0
// ==========================================================================
module sos_multi_dist_calc_onset_window_detector
   import sos_multi_dist_calc_pkg::*;
#(
   parameter int SAMPLE_W    = 16,
   parameter int WINDOW_SIZE = 32,
   parameter int DELAY_W     = 10,
   parameter int RATIO_SHIFT = 1,
   parameter int MIN_ENERGY  = 256
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       clear,
   input  wire logic                       arm,
   input  wire logic                       sample_strobe,
   input  wire logic                       window_end,
   input  wire logic [DELAY_W-1:0]         window_start_idx,
   input  wire logic signed [SAMPLE_W-1:0] sample,
   output logic                            onset,
   output logic                            resolved,
   output logic [DELAY_W-1:0]              delay
);
   localparam int SUM_W = sum_width(SAMPLE_W, WINDOW_SIZE);

   logic [SAMPLE_W-1:0] mag;
   logic [SUM_W-1:0]    cur, prev, pp, cur_next;
   logic [SUM_W:0]      thresh;
   logic [1:0]          seen;

   // Most-negative sample maps to 2^(SAMPLE_W-1), which still fits unsigned.
   assign mag      = sample[SAMPLE_W-1] ? (~unsigned'(sample) + SAMPLE_W'(1)) : unsigned'(sample);
   assign cur_next = cur + SUM_W'(mag);
   assign thresh   = {1'b0, pp} + {1'b0, (pp >> RATIO_SHIFT)};
   assign onset    = window_end && !resolved && (seen == 2'd2)
                  && (cur_next > prev) && ({1'b0, cur_next} > thresh)
                  && (cur_next >= SUM_W'(MIN_ENERGY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= '0;
         prev     <= '0;
         pp       <= '0;
         seen     <= '0;
         resolved <= 1'b0;
         delay    <= '0;
      end else if (clear) begin
         cur      <= '0;
         prev     <= '0;
         pp       <= '0;
         seen     <= '0;
         resolved <= 1'b0;
         delay    <= '0;
      end else if (arm && !resolved) begin
         cur  <= '0;
         prev <= '0;
         pp   <= '0;
         seen <= '0;
      end else if (sample_strobe && !resolved) begin
         if (onset) begin
            resolved <= 1'b1;
            delay    <= window_start_idx;
         end else if (window_end) begin
            pp   <= prev;
            prev <= cur_next;
            cur  <= '0;
            if (seen != 2'd2) seen <= seen + 2'd1;
         end else begin
            cur <= cur_next;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/sos_multi_dist_calc.sv
`default_nettype none
// ==========================================================================
// sos_multi_dist_calc : multi-channel speed-of-sound ranging controller.  Rev 1.0
// ==========================================================================
module sos_multi_dist_calc
   import sos_multi_dist_calc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SAMPLE_W    = 16,
   parameter int WINDOW_SIZE = 32,
   parameter int MAX_DELAY   = 1023,
   parameter int RATIO_SHIFT = 1,
   parameter int MIN_ENERGY  = 256,
   parameter int MAX_RETRIES = 3
) (
   input wire logic               clk_in,
   input wire logic               rst_in,
   sos_multi_dist_calc_if.slave   bus
);
   localparam int DELAY_W = delay_width(MAX_DELAY);
   localparam int WIN_W   = $clog2(WINDOW_SIZE);
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   fsm_t                state;
   logic [DELAY_W-1:0]  sample_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [RETRY_W-1:0]  retry_cnt;
   logic                req, busy, done;
   logic [NUM_CH-1:0]   fail, onset, resolved;
   logic [DELAY_W-1:0]  delay_arr [NUM_CH];

   logic               listen_step, win_end, arm, clear, all_res, timeout;
   logic [DELAY_W-1:0] win_start;

   assign listen_step = (state == LISTEN) && bus.step_in;
   assign win_end     = listen_step && (win_cnt == WIN_W'(WINDOW_SIZE - 1));
   assign win_start   = sample_cnt - DELAY_W'(WINDOW_SIZE - 1);
   assign arm         = (state == FIRE) && bus.impulse_done_in;
   assign clear       = (state == IDLE) && bus.trigger_in;
   // Counts channels resolving on this very step so the last resolve beats a timeout.
   assign all_res     = &(resolved | onset);
   assign timeout     = listen_step && (sample_cnt == DELAY_W'(MAX_DELAY - 1));

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         sos_multi_dist_calc_onset_window_detector #(
            .SAMPLE_W    (SAMPLE_W),
            .WINDOW_SIZE (WINDOW_SIZE),
            .DELAY_W     (DELAY_W),
            .RATIO_SHIFT (RATIO_SHIFT),
            .MIN_ENERGY  (MIN_ENERGY)
         ) u_det (
            .clk              (clk_in),
            .rst_n            (rst_in),
            .clear            (clear),
            .arm              (arm),
            .sample_strobe    (listen_step),
            .window_end       (win_end),
            .window_start_idx (win_start),
            .sample           (bus.mic_in[c*SAMPLE_W +: SAMPLE_W]),
            .onset            (onset[c]),
            .resolved         (resolved[c]),
            .delay            (delay_arr[c])
         );
         assign bus.delay_out[c*DELAY_W +: DELAY_W] = delay_arr[c];
      end
   endgenerate

   assign bus.impulse_req_out = req;
   assign bus.busy_out        = busy;
   assign bus.done_out        = done;
   assign bus.fail_out        = fail;
   assign bus.delay_valid_out = resolved;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         sample_cnt <= '0;
         win_cnt    <= '0;
         retry_cnt  <= '0;
         req        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.trigger_in) begin
               state     <= FIRE;
               req       <= 1'b1;
               busy      <= 1'b1;
               fail      <= '0;
               retry_cnt <= '0;
            end
            FIRE: if (bus.impulse_done_in) begin
               state      <= LISTEN;
               req        <= 1'b0;
               sample_cnt <= '0;
               win_cnt    <= '0;
            end
            LISTEN: if (bus.step_in) begin
               sample_cnt <= sample_cnt + DELAY_W'(1);
               win_cnt    <= win_end ? '0 : win_cnt + WIN_W'(1);
               if (all_res) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (timeout) begin
                  if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                     retry_cnt <= retry_cnt + RETRY_W'(1);
                     state     <= FIRE;
                     req       <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     fail  <= ~(resolved | onset);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sos_multi_dist_calc.sv
`default_nettype none
// ==========================================================================
// tb_sos_multi_dist_calc : directed scoreboard bench for sos_multi_dist_calc.  Rev 1.0
// ==========================================================================
module tb_sos_multi_dist_calc;
   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = 16;
   localparam int DELAY_W  = 10;

   typedef struct {
      logic [NUM_CH*DELAY_W-1:0] delay;
      logic [NUM_CH-1:0]         valid;
      logic [NUM_CH-1:0]         fail;
      int                        impulses;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   exp_t sb [$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sos_multi_dist_calc_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DELAY_W(DELAY_W)) bus ();

   sos_multi_dist_calc dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic signed [15:0] mic_val(input int scen, input int attempt,
                                                  input int ch, input int idx);
      logic signed [15:0] v;
      v = 16'sd0;
      case (scen)
         2: if (ch == 0) v = (idx < 96) ? ((idx % 2 == 1) ? -16'sd10 : 16'sd10) : 16'sd1000;
         3: if (idx >= 64 * (ch + 1)) v = 16'sd2000;
         4: begin
            if (ch == 1) v = (idx >= 64 && idx < 96) ? 16'sh8000 : 16'sd0;
            else if (idx >= 64) v = 16'sd2000;
         end
         5: begin
            if (attempt == 1) begin
               if ((ch == 0 && idx >= 64) || (ch == 1 && idx >= 128) || (ch == 3 && idx >= 192))
                  v = 16'sd2000;
            end else if (ch == 2 && idx >= 160) begin
               v = 16'sd2000;
            end
         end
         default: v = 16'sd0;
      endcase
      return v;
   endfunction

   function automatic exp_t exp_of(input int scen);
      exp_t e;
      e.delay = '0; e.valid = '0; e.fail = '0; e.impulses = 1;
      case (scen)
         1: begin e.fail = 4'hF; e.impulses = 4; end
         2: begin e.delay = {30'd0, 10'd96}; e.valid = 4'h1; e.fail = 4'hE; e.impulses = 4; end
         3: begin e.delay = {10'd256, 10'd192, 10'd128, 10'd64}; e.valid = 4'hF; end
         4: begin e.delay = {10'd64, 10'd64, 10'd64, 10'd64}; e.valid = 4'hF; end
         5: begin e.delay = {10'd192, 10'd160, 10'd128, 10'd64}; e.valid = 4'hF; e.impulses = 2; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic do_reset(input string tag);
      #1 rst_n = 1'b0;
      #1;
      chk({tag, "_req"}, 64'(bus.impulse_req_out), 64'd0);
      chk({tag, "_outputs"}, 64'({bus.busy_out, bus.done_out, bus.delay_valid_out,
                                  bus.fail_out, bus.delay_out}), 64'd0);
      bus.step_in = 1'b0; bus.impulse_done_in = 1'b0; bus.trigger_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // abort_mode: 0 normal, 1 reset mid-LISTEN, 2 reset mid-FIRE
   task automatic run(input int scen, input int abort_mode);
      int   attempt  = 0;
      int   idx      = 0;
      int   req_wait = 0;
      int   impulses = 0;
      bit   finished = 0;
      bit   lat_chk  = 0;
      exp_t e;
      if (abort_mode == 0) sb.push_back(exp_of(scen));
      @(negedge clk);
      bus.trigger_in = 1'b1;
      @(negedge clk);
      bus.trigger_in = 1'b0;
      for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
         @(negedge clk);
         bus.step_in = 1'b0; bus.impulse_done_in = 1'b0; bus.trigger_in = 1'b0;
         if (lat_chk) begin
            chk("valid_latency_hi", 64'(bus.delay_valid_out[0]), 64'd1);
            lat_chk = 0;
         end
         if (bus.done_out) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'(bus.done_out), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("delay_out", 64'(bus.delay_out), 64'(e.delay));
               chk("delay_valid_out", 64'(bus.delay_valid_out), 64'(e.valid));
               chk("fail_out", 64'(bus.fail_out), 64'(e.fail));
               chk("impulse_count", 64'(impulses), 64'(e.impulses));
            end
            @(negedge clk);
            chk("done_one_cycle", 64'(bus.done_out), 64'd0);
            chk("busy_after_done", 64'(bus.busy_out), 64'd0);
            finished = 1;
         end else if (bus.impulse_req_out) begin
            if (abort_mode == 2 && req_wait == 1) begin
               do_reset("reset_in_fire");
               finished = 1;
            end else if (req_wait == 2) begin
               // Step and trigger alongside impulse_done must both be ignored.
               bus.impulse_done_in = 1'b1;
               bus.step_in         = 1'b1;
               bus.trigger_in      = 1'b1;
               for (int ch = 0; ch < NUM_CH; ch++) bus.mic_in[ch*SAMPLE_W +: SAMPLE_W] = 16'sd30000;
               attempt++; impulses++; idx = 0; req_wait = 0;
            end else begin
               req_wait++;
            end
         end else if (attempt > 0 && cyc % 2 == 0) begin
            if (abort_mode == 1 && idx == 150) begin
               chk("valid_before_reset", 64'(bus.delay_valid_out[0]), 64'd1);
               do_reset("reset_in_listen");
               finished = 1;
            end else begin
               bus.step_in = 1'b1;
               for (int ch = 0; ch < NUM_CH; ch++)
                  bus.mic_in[ch*SAMPLE_W +: SAMPLE_W] = mic_val(scen, attempt, ch, idx);
               if (idx == 10) chk("busy_in_listen", 64'(bus.busy_out), 64'd1);
               if (scen == 3 && idx == 100) bus.trigger_in = 1'b1;
               if (scen == 3 && idx == 95) begin
                  chk("valid_latency_lo", 64'(bus.delay_valid_out[0]), 64'd0);
                  lat_chk = 1;
               end
               idx++;
            end
         end
      end
      chk("run_completed", 64'(finished), 64'd1);
   endtask

   initial begin
      bus.step_in = 1'b0; bus.trigger_in = 1'b0; bus.impulse_done_in = 1'b0; bus.mic_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({bus.impulse_req_out, bus.busy_out, bus.done_out, bus.delay_valid_out,
                                bus.fail_out, bus.delay_out}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", 64'({bus.impulse_req_out, bus.busy_out}), 64'd0);

      run(3, 0);
      repeat (5) @(negedge clk);
      chk("hold_valid", 64'(bus.delay_valid_out), 64'hF);
      chk("hold_delay", 64'(bus.delay_out), 64'({10'd256, 10'd192, 10'd128, 10'd64}));

      run(4, 0);
      run(2, 0);
      run(5, 0);
      run(1, 0);
      run(3, 1);
      run(3, 2);
      run(3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
